// File: rtl/mul_share_seq.sv
// mul_share_seq: two-requester round-robin front end feeding one iterative shift-and-add multiplier
module mul_share_seq #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    output logic           ack0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           ack1,
    output logic           busy,
    output logic           out_valid,
    output logic           out_id,
    output logic [2*W-1:0] product,
    input  logic           out_ready
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d, acc_lo_q, acc_lo_d;
    logic [W:0]     acc_hi_q, acc_hi_d, sum;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           id_q, id_d, rr_last_q, rr_last_d, out_id_q, out_id_d;
    logic [2*W-1:0] product_q, product_d;
    logic           grant0, grant1;
    // on a tie the requester that was not served last wins
    always_comb begin
        grant0 = req0 & (~req1 | rr_last_q);
        grant1 = req1 & (~req0 | ~rr_last_q);
    end
    assign ack0      = (state_q == IDLE) & grant0;
    assign ack1      = (state_q == IDLE) & grant1;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign out_id    = out_id_q;
    assign product   = product_q;
    // accept a pair, run W add/shift iterations on the single adder row, then hold the result
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        out_id_d  = out_id_q;
        product_d = product_q;
        sum       = acc_hi_q + (W+1)'(acc_lo_q[0] ? mcand_q : {W{1'b0}});
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    mcand_d   = grant1 ? a1 : a0;
                    acc_lo_d  = grant1 ? b1 : b0;
                    acc_hi_d  = '0;
                    cnt_d     = '0;
                    id_d      = grant1;
                    rr_last_d = grant1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_hi_d = {1'b0, sum[W:1]};
                acc_lo_d = {sum[0], acc_lo_q[W-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    state_d   = DONE;
                    product_d = {sum, acc_lo_q[W-1:1]};
                    out_id_d  = id_q;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // state register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            rr_last_q <= 1'b1;
            out_id_q  <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
            out_id_q  <= out_id_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_mul_share_seq.sv
// tb_mul_share_seq: vector table, corner-case sequences and random operations checked against plain a*b
module tb_mul_share_seq;
    localparam int W = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0 = 0, req1 = 0, out_ready = 1;
    logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic ack0, ack1, busy, out_valid, out_id;
    logic [2*W-1:0] product;
    int n_cmp = 0, n_err = 0;

    mul_share_seq #(.W(W), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
        .busy(busy), .out_valid(out_valid), .out_id(out_id),
        .product(product), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r;
        logic [3:0] a, b;
        logic [7:0] p;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        req0 = 0; req1 = 0; out_ready = 1;
        @(posedge clk); #5 rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    // present one pair, wait for ack, then for the result; bp cycles of backpressure in DONE
    task automatic run_op(input bit r, input logic [3:0] a, input logic [3:0] b, input int bp,
                          output logic [7:0] p, output bit id, output int lat);
        int t;
        bit stable;
        out_ready = (bp == 0);
        if (r) begin req1 = 1; a1 = a; b1 = b; end
        else begin req0 = 1; a0 = a; b0 = b; end
        #1;
        t = 0;
        while (!(r ? ack1 : ack0) && t < 50) begin @(posedge clk); #2; t++; end
        if (t >= 50) chk("ack_timeout", 16'(t), 0);
        @(posedge clk); #2;
        chk("ack_single_cycle", r ? ack1 : ack0, 0);
        if (r) req1 = 0; else req0 = 0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(posedge clk); #2; lat++; end
        p = product;
        id = out_id;
        stable = 1;
        repeat (bp) begin
            @(posedge clk); #2;
            if (!out_valid || product !== p || out_id !== id) stable = 0;
        end
        if (bp > 0) chk("bp_hold", stable, 1);
        out_ready = 1;
        @(posedge clk); #2;
        chk("valid_drop", out_valid, 0);
    endtask

    initial begin
        logic [7:0] p;
        bit id;
        int lat, ack_q[$], ack_t[$], res_p[$], res_id[$];
        bit seen, ok;
        vt[0] = '{0, 13, 11, 143};
        vt[1] = '{1, 15, 15, 225};
        vt[2] = '{0, 0, 9, 0};
        vt[3] = '{0, 1, 1, 1};
        vt[4] = '{1, 9, 9, 81};
        vt[5] = '{0, 15, 1, 15};

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_id", out_id, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        @(posedge clk); #5 rst_n = 1'b1;
        @(posedge clk); #2;

        foreach (vt[i]) begin
            run_op(vt[i].r, vt[i].a, vt[i].b, 0, p, id, lat);
            chk($sformatf("vec%0d_product", i), p, vt[i].p);
            chk($sformatf("vec%0d_id", i), id, vt[i].r);
            chk($sformatf("vec%0d_latency", i), 16'(lat), 16'(W + 1));
        end

        // both requesters held continuously from reset
        do_reset();
        req0 = 1; a0 = 3; b0 = 5; req1 = 1; a1 = 7; b1 = 6;
        #1;
        for (int c = 0; c < 80 && res_p.size() < 4; c++) begin
            if (ack0) begin ack_q.push_back(0); ack_t.push_back(c); end
            if (ack1) begin ack_q.push_back(1); ack_t.push_back(c); end
            if (out_valid) begin res_p.push_back(product); res_id.push_back(out_id); end
            @(posedge clk); #2;
        end
        req0 = 0; req1 = 0;
        chk("tie_result_count", 16'(res_p.size()), 4);
        chk("tie_ack_count_min", 16'(ack_q.size() >= 4), 1);
        for (int i = 0; i < 4 && i < ack_q.size() && i < res_p.size(); i++) begin
            chk($sformatf("tie_ack%0d", i), ack_q[i], 16'(i % 2));
            chk($sformatf("tie_prod%0d", i), 16'(res_p[i]), (i % 2) ? 42 : 15);
            chk($sformatf("tie_id%0d", i), 16'(res_id[i]), 16'(i % 2));
            if (i > 0) chk($sformatf("tie_spacing%0d", i), 16'(ack_t[i] - ack_t[i-1]), 16'(W + 2));
        end

        // backpressure with requester 1 waiting
        do_reset();
        out_ready = 0;
        req0 = 1; a0 = 2; b0 = 3;
        #1;
        chk("bp_ack0", ack0, 1);
        @(posedge clk); #2;
        req0 = 0; req1 = 1; a1 = 4; b1 = 5;
        for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #2; end
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            if (!out_valid || product !== 8'd6 || out_id !== 1'b0 || ack1 || !busy) ok = 0;
            @(posedge clk); #2;
        end
        chk("bp_stable10", ok, 1);
        chk("bp_product", product, 6);
        out_ready = 1;
        #1;
        chk("bp_no_ack_in_done", ack1, 0);
        @(posedge clk); #2;
        chk("bp_valid_low", out_valid, 0);
        chk("bp_ack1_after", ack1, 1);
        @(posedge clk); #2;
        req1 = 0;
        for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #2; end
        chk("bp_second_product", product, 20);
        chk("bp_second_id", out_id, 1);
        @(posedge clk); #2;

        // reset pulled mid-CALC between edges
        req0 = 1; a0 = 5; b0 = 5;
        #1;
        chk("ar_ack", ack0, 1);
        @(posedge clk); #2;
        req0 = 0;
        @(posedge clk); #3;
        chk("ar_busy_before", busy, 1);
        rst_n = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_product", product, 0);
        chk("ar_id", out_id, 0);
        chk("ar_acks", {ack0, ack1}, 0);
        @(posedge clk); #5 rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #2;
            if (out_valid || busy || ack0) seen = 1;
        end
        chk("ar_no_stale", seen, 0);
        run_op(0, 9, 9, 0, p, id, lat);
        chk("ar_after_product", p, 81);
        chk("ar_after_latency", 16'(lat), 16'(W + 1));

        // full sweep on requester 0
        ok = 1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                run_op(0, 4'(a), 4'(b), 0, p, id, lat);
                if (p !== 8'(a * b) || id !== 1'b0 || lat != W + 1) begin
                    ok = 0;
                    $display("FAIL sweep %0d*%0d: got %0d lat %0d", a, b, p, lat);
                end
            end
        chk("sweep_all", ok, 1);

        // random requesters, operands and backpressure
        for (int i = 0; i < 60; i++) begin
            bit r;
            logic [3:0] a, b;
            int bp;
            r = 1'($urandom);
            a = 4'($urandom);
            b = 4'($urandom);
            bp = $urandom_range(0, 3);
            run_op(r, a, b, bp, p, id, lat);
            chk("rand_product", p, 8'(a) * 8'(b));
            chk("rand_id", id, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_share_seq.md
Name: mul_share_seq

Overview:
- Shared, multi-cycle shift-and-add multiplier with a built-in two-requester round-robin arbiter.
- Reuses one W-bit adder row, the same structure as one ripple-carry row of the array multiplier, and iterates it over W cycles instead of instantiating W-1 rows.
- Sits between two client blocks that need unsigned WxW products and cannot each afford a full array.
- Result is returned with the requester ID and held under a valid/ready handshake.

Parameters:
- W, 4, operand width in bits; product is 2W bits.
- CW, 3, iteration counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 has an operand pair pending.
- a0  input  W  requester 0 multiplicand.
- b0  input  W  requester 0 multiplier.
- ack0  output  1  requester 0 operands accepted this cycle.
- req1  input  1  requester 1 has an operand pair pending.
- a1  input  W  requester 1 multiplicand.
- b1  input  W  requester 1 multiplier.
- ack1  output  1  requester 1 operands accepted this cycle.
- busy  output  1  high in CALC and DONE.
- out_valid  output  1  product is valid.
- out_id  output  1  requester that owns the product.
- product  output  2W  unsigned a*b.
- out_ready  input  1  consumer accepts the product.

Behaviour:
- Reset, asynchronous on rst_n low, regardless of state:
  - state=IDLE, ack0=ack1=0, busy=0, out_valid=0, out_id=0, product=0.
  - Accumulator and counter cleared; rr_last=1, so requester 0 wins the first tie.
- States: IDLE, CALC, DONE.
- IDLE:
  - ackN is combinational: ackN = (state==IDLE) & grantN.
  - Only req0 high -> grant 0. Only req1 high -> grant 1.
  - Both high -> grant the requester not equal to rr_last.
  - On a grant at edge k:
    - Latch mcand=aN and mplier=bN.
    - acc_hi (W+1 bits) = 0; acc_lo = mplier; cnt=0.
    - id=N; rr_last=N; state -> CALC.
  - No req -> stay in IDLE.
- Requester rule: reqN and its operands must stay stable until the cycle ackN=1. After that, the requester may drop req or present the next pair. A req arriving while busy is not acked; it waits.
- CALC: one iteration per cycle.
  - sum = acc_hi[W-1:0] + (acc_lo[0] ? mcand : 0), W+1 bits including carry.
  - {acc_hi, acc_lo} <= {sum, acc_hi[W-1:0]... } is implemented as: shift the 2W+1-bit value {sum, acc_lo} right by 1; the top bit becomes 0.
  - cnt++. After exactly W CALC cycles, state -> DONE.
- DONE:
  - out_valid=1, product={acc_hi[W-1:0], acc_lo}, out_id=id.
  - All three outputs are held stable while out_ready=0, for any length of backpressure.
  - out_valid & out_ready at an edge -> state IDLE and out_valid=0 next cycle.
  - product and out_id keep their last value until the next DONE.
- Latency:
  - Acceptance edge k -> out_valid high from cycle k+W+1.
  - Minimum spacing between acks is W+2 cycles, with out_ready tied high.
- Arithmetic:
  - Unsigned only. Full 2W-bit result, no truncation. Max (2^W-1)^2 fits exactly.
  - 0 * x = 0 still takes the full W iterations; there is no early exit.
- Fairness:
  - rr_last updates only on a grant.
  - A requester that holds req continuously while the other also requests is served at most every second transaction.
- Reset mid-CALC or mid-DONE:
  - The operation is abandoned and no out_valid pulse occurs.
  - The requester already received ack and is not re-acked.
- busy = (state != IDLE).

Test Plan:
- Single request, W=4: req0=1, a0=13, b0=11, out_ready=1.
  - ack0 for exactly 1 cycle.
  - out_valid exactly 5 cycles after the ack cycle, product=143, out_id=0.
- Extremes:
  - a1=15, b1=15 -> product=225, out_id=1.
  - a0=0, b0=9 -> product=0 after the same W+1 latency.
  - a0=1, b0=1 -> product=1.
- Tie arbitration from reset: req0 and req1 both held high with distinct operands (3*5, 7*6).
  - Acks alternate 0,1,0,1.
  - Results 15 (id 0) then 42 (id 1), repeating.
  - Neither requester is acked twice in a row.
- Backpressure: out_ready=0 for 10 cycles in DONE, with req1 pending.
  - product and out_id stay stable; out_valid stays 1; no ack1.
  - Raise out_ready -> one-cycle handshake, ack1 in the following IDLE cycle.
- Async reset: pull rst_n low mid-CALC, between clock edges.
  - All outputs go to 0 immediately.
  - After release, no stale out_valid.
  - A new request 9*9 -> 81 with normal latency.
- Exhaustive sweep: all 256 (a,b) pairs via requester 0 -> every product matches a*b.
